// File: rtl/updown_counter.sv
// Parametrised synchronous up/down counter with limit, parallel load, wrap/saturate mode and terminal-count pulse.
// Optional wrap-event counter output `wrap_count` is built only when UDC_WRAPCNT_EN is defined.
module updown_counter #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter int              WRAP_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             zero,
  output logic             at_limit
`ifdef UDC_WRAPCNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_count
`endif
);

  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;
  logic             boundary;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_count = counter;
    boundary   = 1'b0;
    if (up) begin
      if (counter >= limit) begin
        boundary   = 1'b1;
        next_count = sat ? limit : '0;
      end else begin
        next_count = counter + 1'b1;
      end
    end else begin
      if (counter == '0) begin
        boundary   = 1'b1;
        next_count = sat ? '0 : limit;
      end else if (counter > limit) begin
        // Pulling an out-of-range count back into range is a correction, not a boundary event.
        next_count = limit;
      end else begin
        next_count = counter - 1'b1;
      end
    end
  end

  assign load_clamped = (load_val < limit) ? load_val : limit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= RESET_VAL;
      tc      <= 1'b0;
    end else if (load) begin
      counter <= load_clamped;
      tc      <= 1'b0;
    end else if (en) begin
      counter <= next_count;
      tc      <= boundary;
    end else begin
      tc      <= 1'b0;
    end
  end

  assign zero     = (counter == '0);
  assign at_limit = (counter >= limit);

`ifdef UDC_WRAPCNT_EN
  always_ff @(posedge clk) begin
    if (reset || load) begin
      wrap_count <= '0;
    end else if (en && boundary && !sat && (wrap_count != {WRAP_W{1'b1}})) begin
      wrap_count <= wrap_count + 1'b1;
    end
  end
`else
  localparam int unused_wrap_w = WRAP_W;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: hand-written vector table, random run against a behavioural model,
// and (with UDC_WRAPCNT_EN) a wrap_count saturation sequence.
module tb_updown_counter;

  localparam int WIDTH  = 4;
  localparam int WRAP_W = 2;
  localparam logic [WIDTH-1:0] RV = 4'hF;

  logic             clk = 1'b0;
  logic             reset, en, up, load, sat;
  logic [WIDTH-1:0] load_val, limit;
  logic [WIDTH-1:0] counter;
  logic             tc, zero, at_limit;
`ifdef UDC_WRAPCNT_EN
  logic [WRAP_W-1:0] wrap_count;
`endif

  updown_counter #(.WIDTH(WIDTH), .RESET_VAL(RV), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .sat(sat),
    .counter(counter), .tc(tc), .zero(zero), .at_limit(at_limit)
`ifdef UDC_WRAPCNT_EN
    , .wrap_count(wrap_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             reset, en, up, load, sat;
    logic [WIDTH-1:0] load_val, limit;
    logic [WIDTH-1:0] exp_cnt;
    logic             exp_tc;
  } vec_t;

  typedef struct {
    string             name;
    logic [WIDTH-1:0]  cnt;
    logic              tc;
    logic              zero;
    logic              at_lim;
    logic              chk_wc;
    logic [WRAP_W-1:0] wc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state
  logic [WIDTH-1:0]  m_cnt;
  logic [WRAP_W-1:0] m_wc;

  function automatic vec_t mk(string nm, logic r, logic e, logic u, logic l, logic [WIDTH-1:0] lv,
                              logic [WIDTH-1:0] lim, logic s, logic [WIDTH-1:0] ec, logic et);
    vec_t v;
    v.name = nm; v.reset = r; v.en = e; v.up = u; v.load = l; v.load_val = lv;
    v.limit = lim; v.sat = s; v.exp_cnt = ec; v.exp_tc = et;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.reset; en = v.en; up = v.up; load = v.load;
    load_val = v.load_val; limit = v.limit; sat = v.sat;
  endtask

  // Apply one cycle of stimulus, then compare the DUT against the oldest queued expectation.
  task automatic step_and_check();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".counter"},  32'(counter),  32'(e.cnt));
    check({e.name, ".tc"},       32'(tc),       32'(e.tc));
    check({e.name, ".zero"},     32'(zero),     32'(e.zero));
    check({e.name, ".at_limit"}, 32'(at_limit), 32'(e.at_lim));
`ifdef UDC_WRAPCNT_EN
    if (e.chk_wc) check({e.name, ".wrap_count"}, 32'(wrap_count), 32'(e.wc));
`endif
  endtask

  // Spec-level model of one edge; returns expected tc and updates model state.
  task automatic model_step(input vec_t v, output logic exp_tc);
    logic bnd;
    bnd = 1'b0;
    if (v.reset) begin
      m_cnt = RV; m_wc = '0;
    end else if (v.load) begin
      m_cnt = (v.load_val > v.limit) ? v.limit : v.load_val;
      m_wc  = '0;
    end else if (v.en) begin
      if (v.up) begin
        if (m_cnt < v.limit) m_cnt = m_cnt + 1'b1;
        else begin bnd = 1'b1; m_cnt = v.sat ? v.limit : '0; end
      end else begin
        if (m_cnt == 0) begin bnd = 1'b1; m_cnt = v.sat ? '0 : v.limit; end
        else if (m_cnt > v.limit) m_cnt = v.limit;
        else m_cnt = m_cnt - 1'b1;
      end
      if (bnd && !v.sat && m_wc != {WRAP_W{1'b1}}) m_wc = m_wc + 1'b1;
    end
    exp_tc = bnd;
  endtask

  task automatic push_exp(input string nm, input logic [WIDTH-1:0] c, input logic t,
                          input logic [WIDTH-1:0] lim, input logic cw, input logic [WRAP_W-1:0] w);
    exp_t e;
    e.name = nm; e.cnt = c; e.tc = t; e.zero = (c == 0); e.at_lim = (c >= lim);
    e.chk_wc = cw; e.wc = w;
    sb.push_back(e);
  endtask

  initial begin
    vec_t v;
    logic et;

    //            name          rst en up ld lv    lim   sat cnt   tc
    tbl.push_back(mk("reset_wins", 1, 1, 1, 1, 4'd3, 4'd9, 0, 4'hF, 0));
    tbl.push_back(mk("load2",      0, 0, 0, 1, 4'd2, 4'd9, 0, 4'd2, 0));
    tbl.push_back(mk("dn_wrap_a",  0, 1, 0, 0, 4'd0, 4'd9, 0, 4'd1, 0));
    tbl.push_back(mk("dn_wrap_b",  0, 1, 0, 0, 4'd0, 4'd9, 0, 4'd0, 0));
    tbl.push_back(mk("dn_wrap_c",  0, 1, 0, 0, 4'd0, 4'd9, 0, 4'd9, 1));
    tbl.push_back(mk("dn_wrap_d",  0, 1, 0, 0, 4'd0, 4'd9, 0, 4'd8, 0));
    tbl.push_back(mk("load7",      0, 0, 1, 1, 4'd7, 4'd9, 1, 4'd7, 0));
    tbl.push_back(mk("up_sat_a",   0, 1, 1, 0, 4'd0, 4'd9, 1, 4'd8, 0));
    tbl.push_back(mk("up_sat_b",   0, 1, 1, 0, 4'd0, 4'd9, 1, 4'd9, 0));
    tbl.push_back(mk("up_sat_c",   0, 1, 1, 0, 4'd0, 4'd9, 1, 4'd9, 1));
    tbl.push_back(mk("up_sat_d",   0, 1, 1, 0, 4'd0, 4'd9, 1, 4'd9, 1));
    tbl.push_back(mk("load_clamp", 0, 1, 1, 1, 4'd12,4'd9, 1, 4'd9, 0));
    tbl.push_back(mk("lim_drop",   0, 1, 0, 0, 4'd0, 4'd5, 1, 4'd5, 0));
    tbl.push_back(mk("idle_hold",  0, 0, 0, 0, 4'd0, 4'd5, 1, 4'd5, 0));
    tbl.push_back(mk("lim0_a",     0, 1, 1, 0, 4'd0, 4'd0, 0, 4'd0, 1));
    tbl.push_back(mk("lim0_b",     0, 1, 1, 0, 4'd0, 4'd0, 0, 4'd0, 1));
    tbl.push_back(mk("lim0_c",     0, 1, 1, 0, 4'd0, 4'd0, 0, 4'd0, 1));
    tbl.push_back(mk("lim0_dn",    0, 1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 1));
    tbl.push_back(mk("dn_sat_0",   0, 1, 0, 0, 4'd0, 4'd6, 1, 4'd0, 1));
    tbl.push_back(mk("reset_mid",  1, 1, 1, 1, 4'd4, 4'd9, 0, 4'hF, 0));
    tbl.push_back(mk("up_over_wr", 0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd0, 1));
    tbl.push_back(mk("up_step",    0, 1, 1, 0, 4'd0, 4'd9, 1, 4'd1, 0));
    tbl.push_back(mk("load_ovr_en",0, 1, 0, 1, 4'd4, 4'd9, 0, 4'd4, 0));
    tbl.push_back(mk("dn_over_sat",0, 1, 0, 0, 4'd0, 4'd3, 1, 4'd3, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      push_exp(tbl[i].name, tbl[i].exp_cnt, tbl[i].exp_tc, tbl[i].limit, 1'b0, '0);
      step_and_check();
    end

    // Random run against the model, starting from a reset.
    v = mk("rnd_reset", 1, 0, 0, 0, 4'd0, 4'd9, 0, 4'd0, 0);
    for (int i = 0; i < 400; i++) begin
      if (i > 0) begin
        v.name     = $sformatf("rnd%0d", i);
        v.reset    = ($urandom_range(0, 31) == 0);
        v.load     = ($urandom_range(0, 7) == 0);
        v.en       = ($urandom_range(0, 3) != 0);
        v.up       = $urandom_range(0, 1);
        v.sat      = ($urandom_range(0, 3) == 0);
        v.load_val = WIDTH'($urandom_range(0, 15));
        v.limit    = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, 15)) : v.limit;
      end
      drive(v);
      model_step(v, et);
      push_exp(v.name, m_cnt, et, v.limit, 1'b1, m_wc);
      step_and_check();
    end

`ifdef UDC_WRAPCNT_EN
    // Wrap counter: limit 3, wrap mode, 20 up-steps -> one wrap every 4 steps, saturating at 3.
    drive(mk("wc_load0", 0, 0, 1, 1, 4'd0, 4'd3, 0, 4'd0, 0));
    push_exp("wc_load0", 4'd0, 1'b0, 4'd3, 1'b1, 2'd0);
    step_and_check();
    for (int k = 1; k <= 20; k++) begin
      drive(mk($sformatf("wc_up%0d", k), 0, 1, 1, 0, 4'd0, 4'd3, 0, 4'd0, 0));
      push_exp($sformatf("wc_up%0d", k), WIDTH'(k % 4), (k % 4) == 0, 4'd3, 1'b1,
               WRAP_W'((k / 4) > 3 ? 3 : (k / 4)));
      step_and_check();
    end
    drive(mk("wc_clear", 0, 0, 1, 1, 4'd1, 4'd3, 0, 4'd0, 0));
    push_exp("wc_clear", 4'd1, 1'b0, 4'd3, 1'b1, 2'd0);
    step_and_check();
`endif

    if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
